// File: rtl/simu_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// simu_ram_arb_pkg : shared types for the two-master RAM arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package simu_ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  function automatic owner_t other_owner(input owner_t id);
    return ~id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simu_ram_arb_pick.sv
// ---------------------------------------------------------------------------
// simu_ram_arb_pick : tie-break winner select; RAM_ARB_ROUND_ROBIN_EN enables RR
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module simu_ram_arb_pick
  import simu_ram_arb_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       gnt_valid,
  input  owner_t     gnt_id,
  output owner_t     winner
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  owner_t last_grant;

  // Reset to m1 so that m0 takes the first tie.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant <= 1'b1;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) begin
      winner = other_owner(last_grant);
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, aclk, aresetn, gnt_valid, gnt_id};

  always_comb begin
    winner = 1'b0;
    if (!req[0] && req[1]) begin
      winner = 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/simu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// simu_ram_arbiter : two-master arbiter onto a 1-cycle-latency RAM with lock
// Revision 1.0 -- tie policy selected by RAM_ARB_ROUND_ROBIN_EN
// ---------------------------------------------------------------------------
`default_nettype none

module simu_ram_arbiter
  import simu_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    m0_req,
  input  logic                    m0_lock,
  input  logic                    m0_we,
  input  logic [BUS_WIDTH-1:0]    m0_addr,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_lock,
  input  logic                    m1_we,
  input  logic [BUS_WIDTH-1:0]    m1_addr,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,

  output logic                    ram_ren,
  output logic [BUS_WIDTH-1:0]    ram_raddr,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [DATA_WIDTH/8-1:0] ram_wen,
  output logic [BUS_WIDTH-1:0]    ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata
);

  arb_state_t state, state_nxt;
  logic [1:0] req;
  logic [1:0] lock;
  owner_t     winner;
  logic       gnt_valid;
  owner_t     gnt_id;
  logic [1:0] rd_tag;

  logic                    sel_we;
  logic [BUS_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH/8-1:0] sel_wstrb;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  simu_ram_arb_pick u_pick (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .winner    (winner)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An owner keeps the bus while lock is high, whether or not it requests.
  always_comb begin
    state_nxt = state;
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_valid = 1'b1;
          gnt_id    = winner;
          if (lock[winner]) begin
            state_nxt = winner ? OWN1 : OWN0;
          end
        end
      end
      OWN0: begin
        gnt_valid = req[0];
        gnt_id    = 1'b0;
        if (!lock[0]) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        gnt_valid = req[1];
        gnt_id    = 1'b1;
        if (!lock[1]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign m0_gnt = gnt_valid & ~gnt_id;
  assign m1_gnt = gnt_valid &  gnt_id;

  always_comb begin
    sel_we    = gnt_id ? m1_we    : m0_we;
    sel_addr  = gnt_id ? m1_addr  : m0_addr;
    sel_wstrb = gnt_id ? m1_wstrb : m0_wstrb;
    sel_wdata = gnt_id ? m1_wdata : m0_wdata;
  end

  // A zero write strobe still counts as a granted write beat.
  always_comb begin
    ram_ren   = 1'b0;
    ram_raddr = '0;
    ram_wen   = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (gnt_valid) begin
      if (sel_we) begin
        ram_wen   = sel_wstrb;
        ram_waddr = sel_addr;
        ram_wdata = sel_wdata;
      end else begin
        ram_ren   = 1'b1;
        ram_raddr = sel_addr;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_tag <= 2'b00;
    end else if (ram_ren) begin
      rd_tag <= gnt_id ? 2'b10 : 2'b01;
    end else begin
      rd_tag <= 2'b00;
    end
  end

  assign m0_rvalid = rd_tag[0];
  assign m1_rvalid = rd_tag[1];
  assign m0_rdata  = rd_tag[0] ? ram_rdata : '0;
  assign m1_rdata  = rd_tag[1] ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_simu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_simu_ram_arbiter : directed scenarios plus random traffic vs. a rule model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_simu_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int DW = 32;
  localparam int BW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [BW-1:0] m0_addr, m1_addr;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_ren;
  logic [BW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_rdata, ram_wdata;
  logic [DW/8-1:0] ram_wen;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the lock, who won last, who awaits read data.
  int own, last, pend, win;

  always #5 aclk = ~aclk;

  simu_ram_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit lock_of(input int n);
    return (n == 1) ? m1_lock : m0_lock;
  endfunction

  function automatic bit we_of(input int n);
    return (n == 1) ? m1_we : m0_we;
  endfunction

  task automatic model_reset();
    own  = -1;
    last = 1;
    pend = -1;
  endtask

  task automatic set_m(input int n, input bit rq, input bit lk, input bit we,
                       input logic [BW-1:0] ad, input logic [DW/8-1:0] st,
                       input logic [DW-1:0] wd);
    if (n == 0) begin
      m0_req = rq; m0_lock = lk; m0_we = we; m0_addr = ad; m0_wstrb = st; m0_wdata = wd;
    end else begin
      m1_req = rq; m1_lock = lk; m1_we = we; m1_addr = ad; m1_wstrb = st; m1_wdata = wd;
    end
  endtask

  task automatic idle_inputs();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
  endtask

  // Called in the low phase after inputs settle; compares every output.
  task automatic check_now();
    bit e0, e1;
    logic [BW-1:0]   ea;
    logic [DW/8-1:0] es;
    logic [DW-1:0]   ed;
    e0 = m0_req && (own < 0 || own == 0);
    e1 = m1_req && (own < 0 || own == 1);
    if (e0 && e1)  win = (RR && last == 0) ? 1 : 0;
    else if (e0)   win = 0;
    else if (e1)   win = 1;
    else           win = -1;
    ea = (win == 1) ? m1_addr  : m0_addr;
    es = (win == 1) ? m1_wstrb : m0_wstrb;
    ed = (win == 1) ? m1_wdata : m0_wdata;
    #1;
    chk("gnt", {m1_gnt, m0_gnt}, {(win == 1), (win == 0)});
    if (win >= 0 && !we_of(win)) begin
      chk("rd_bus", {ram_ren, ram_raddr}, {1'b1, ea});
      chk("wr_bus", {ram_wen, ram_waddr, ram_wdata}, '0);
    end else if (win >= 0) begin
      chk("rd_bus", {ram_ren, ram_raddr}, '0);
      chk("wr_bus", {ram_wen, ram_waddr, ram_wdata}, {es, ea, ed});
    end else begin
      chk("rd_bus", {ram_ren, ram_raddr}, '0);
      chk("wr_bus", {ram_wen, ram_waddr, ram_wdata}, '0);
    end
    chk("rvalid", {m1_rvalid, m0_rvalid}, {(pend == 1), (pend == 0)});
    chk("rdata0", m0_rdata, (pend == 0) ? ram_rdata : '0);
    chk("rdata1", m1_rdata, (pend == 1) ? ram_rdata : '0);
  endtask

  task automatic advance();
    @(posedge aclk);
    if (win >= 0) begin
      last = win;
      pend = we_of(win) ? -1 : win;
      own  = lock_of(win) ? win : -1;
    end else begin
      pend = -1;
      if (own >= 0 && !lock_of(own)) own = -1;
    end
    @(negedge aclk);
  endtask

  task automatic cycle();
    check_now();
    advance();
  endtask

  // Pulse reset inside the low phase, releasing well before the next edge.
  task automatic pulse_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    model_reset();
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn   = 1'b0;
    ram_rdata = '0;
    idle_inputs();
    model_reset();
    @(negedge aclk);
    #1;
    chk("reset_out", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ren, ram_wen}, '0);
    aresetn = 1'b1;
    #1;
    check_now();
    advance();

    // Single read with one-cycle latency.
    set_m(0, 1, 0, 0, 32'h1000, '0, '0);
    ram_rdata = 32'hA5A5A5A5;
    check_now();
    chk("rd0_raddr", ram_raddr, 32'h1000);
    advance();
    idle_inputs();
    check_now();
    chk("rd0_rdata", {m1_rvalid, m0_rvalid, m0_rdata}, {2'b01, 32'hA5A5A5A5});
    advance();

    // Contested back-to-back reads.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1, 0, 0, 32'h100 + i, '0, '0);
      set_m(1, 1, 0, 0, 32'h200 + i, '0, '0);
      ram_rdata = $urandom;
      check_now();
      chk("tie_seq", {m1_gnt, m0_gnt}, (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
      advance();
    end
    idle_inputs();
    cycle();

    // m1 locked write burst blocks m0 until after the unlocking beat.
    for (int i = 0; i < 3; i++) begin
      set_m(1, 1, (i < 2), 1, 32'h20 + 4 * i, 4'hF, $urandom);
      set_m(0, (i > 0), 0, 0, 32'h300, '0, '0);
      check_now();
      chk("lock_block", {m1_gnt, m0_gnt}, 2'b10);
      advance();
    end
    set_m(1, 0, 0, 0, '0, '0, '0);
    check_now();
    chk("lock_release", m0_gnt, 1'b1);
    advance();
    idle_inputs();
    cycle();

    // m0 owns while idle: no strobes, m1 held off.
    set_m(0, 1, 1, 0, 32'h400, '0, '0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      set_m(0, 0, 1, 0, '0, '0, '0);
      set_m(1, 1, 0, 1, 32'h500, 4'h3, 32'h12345678);
      check_now();
      chk("own_quiet", {m1_gnt, ram_ren, ram_wen}, '0);
      advance();
    end
    set_m(0, 0, 0, 0, '0, '0, '0);
    cycle();
    cycle();

    // Zero write strobe is still a granted beat.
    idle_inputs();
    set_m(0, 1, 0, 1, 32'h600, 4'h0, 32'hDEADBEEF);
    check_now();
    chk("zero_strb", {m0_gnt, ram_wen}, {1'b1, 4'h0});
    advance();

    // Reset between a read grant and its response edge.
    set_m(0, 1, 0, 0, 32'h700, '0, '0);
    check_now();
    #1 aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("rst_drop", {m1_rvalid, m0_rvalid}, 2'b00);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 1, 0, 0, 32'h800, '0, '0);
    check_now();
    chk("rst_idle", m1_gnt, 1'b1);
    advance();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      set_m(0, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 15), $urandom);
      set_m(1, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 15), $urandom);
      ram_rdata = $urandom;
      if ($urandom_range(0, 99) == 0) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
